// File: rtl/fsmc_slave_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fsmc_pkg
//  Description : Shared types and constants for the FSMC slave arbiter.
//                arb_state_t  - transaction FSM state encoding
//                arb_txn_t    - {idx, we, data} record for the pending buffer
//                               and the in-flight transaction
//                C_DEFAULT_RDATA - read data returned when a read times out
//  Revision    : 1.0 - initial release
// ============================================================================
package fsmc_pkg;

    // Widths of the transaction record. The arbiter parameters default to
    // these values and are expected to match them.
    localparam int ARB_CS_WIDTH   = 2;
    localparam int ARB_DATA_WIDTH = 16;

    localparam logic [ARB_DATA_WIDTH-1:0] C_DEFAULT_RDATA = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [ARB_CS_WIDTH-1:0]   idx;
        logic                      we;
        logic [ARB_DATA_WIDTH-1:0] data;
    } arb_txn_t;

endpackage
`default_nettype wire

// File: rtl/fsmc_slave_arbiter_onehot_enc.sv
`default_nettype none
// ============================================================================
//  Module      : fsmc_onehot_enc
//  Description : One-hot to binary index encoder with a multi-hot flag.
//                The index is the OR of all set bit positions, so it is only
//                meaningful when o_multi is low.
//  Ports       : i_vec   - one-hot input vector
//                o_idx   - binary index of the set bit
//                o_multi - more than one bit of i_vec is set
//  Revision    : 1.0 - initial release
// ============================================================================
module fsmc_onehot_enc #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_multi
);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) begin
                o_idx = o_idx | IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only when two or more are set.
    assign o_multi = |(i_vec & (i_vec - WIDTH'(1)));

endmodule
`default_nettype wire

// File: rtl/fsmc_slave_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fsmc_slave_arbiter
//  Description : Transaction controller behind the FSMC bus interface.
//                Turns chip-select edges into request/acknowledge handshakes
//                toward 2**CS_WIDTH register slaves, returns read data for the
//                host, buffers one pending transaction and keeps sticky error
//                flags for overrun, multi-hot chip-select and timeout.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                cs, state, host_wdata - FSMC interface side
//                host_rdata            - read data for the interface bus driver
//                slv_req/we/wdata      - request toward the slaves
//                slv_ack, slv_rdata    - slave response (packed read data)
//                busy                  - FSM active or pending entry held
//                err_clr, err_*        - sticky error flags and their clear
//  Config      : FSMC_ARB_TIMEOUT_EN - when defined, a request not acked
//                within TIMEOUT_CYCLES is abandoned; otherwise WAIT waits
//                indefinitely and err_timeout is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsmc_slave_arbiter
    import fsmc_pkg::*;
#(
    parameter int                    CS_WIDTH       = ARB_CS_WIDTH,
    parameter int                    DATA_WIDTH     = ARB_DATA_WIDTH,
    parameter int                    TIMEOUT_CYCLES = 64,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA  = C_DEFAULT_RDATA,
    localparam int                   NUM_SLV        = 2**CS_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SLV-1:0]            cs,
    input  logic                          state,
    input  logic [DATA_WIDTH-1:0]         host_wdata,
    output logic [DATA_WIDTH-1:0]         host_rdata,
    output logic [NUM_SLV-1:0]            slv_req,
    output logic                          slv_we,
    output logic [DATA_WIDTH-1:0]         slv_wdata,
    input  logic [NUM_SLV-1:0]            slv_ack,
    input  logic [NUM_SLV*DATA_WIDTH-1:0] slv_rdata,
    output logic                          busy,
    input  logic                          err_clr,
    output logic                          err_overrun,
    output logic                          err_multi_cs,
    output logic                          err_timeout
);

    logic [NUM_SLV-1:0]    r_cs_q;
    logic                  r_state_q;
    logic [CS_WIDTH-1:0]   w_cs_idx;
    logic [CS_WIDTH-1:0]   w_csq_idx;
    logic                  w_cs_multi;
    logic                  w_csq_multi;

    logic                  w_rd_evt;
    logic                  w_wr_evt;
    logic                  w_evt_valid;
    logic                  w_evt_multi;
    arb_txn_t              w_evt;

    arb_state_t            r_fsm;
    arb_txn_t              r_cur;
    arb_txn_t              r_pend;
    logic                  r_pend_vld;

    logic                  w_start_pend;
    logic                  w_start_evt;
    logic                  w_buf_evt;
    logic                  w_overrun;
    arb_txn_t              w_next;
    logic [NUM_SLV-1:0]    w_next_req;
    logic                  w_ack_hit;
    logic [DATA_WIDTH-1:0] w_rdata_arr [NUM_SLV];
    logic [DATA_WIDTH-1:0] w_sel_rdata;

    // ------------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------------
    fsmc_onehot_enc #(
        .WIDTH (NUM_SLV),
        .IDX_W (CS_WIDTH)
    ) u_enc_cs (
        .i_vec   (cs),
        .o_idx   (w_cs_idx),
        .o_multi (w_cs_multi)
    );

    fsmc_onehot_enc #(
        .WIDTH (NUM_SLV),
        .IDX_W (CS_WIDTH)
    ) u_enc_cs_q (
        .i_vec   (r_cs_q),
        .o_idx   (w_csq_idx),
        .o_multi (w_csq_multi)
    );

    // Reads start on the rising select; writes fire when select drops, which
    // is when the interface has the host data captured.
    assign w_rd_evt    = (|(cs & ~r_cs_q)) & state;
    assign w_wr_evt    = (|r_cs_q) & ~(|cs) & ~r_state_q;
    assign w_evt_valid = (w_rd_evt & ~w_cs_multi)  | (w_wr_evt & ~w_csq_multi);
    assign w_evt_multi = (w_rd_evt &  w_cs_multi)  | (w_wr_evt &  w_csq_multi);

    always_comb begin
        w_evt.idx  = w_rd_evt ? w_cs_idx : w_csq_idx;
        w_evt.we   = ~w_rd_evt;
        w_evt.data = w_rd_evt ? '0 : host_wdata;
    end

    // ------------------------------------------------------------------------
    // Scheduling: a buffered entry always goes before a new event. In DONE
    // the buffer drains this cycle, so a simultaneous event can refill it.
    // ------------------------------------------------------------------------
    assign w_start_pend = (r_fsm == DONE) & r_pend_vld;
    assign w_start_evt  = w_evt_valid & ((r_fsm == IDLE) | ((r_fsm == DONE) & ~r_pend_vld));
    assign w_buf_evt    = w_evt_valid & ~w_start_evt & (~r_pend_vld | w_start_pend);
    assign w_overrun    = w_evt_valid & ~w_start_evt & r_pend_vld & ~w_start_pend;
    assign w_next       = w_start_pend ? r_pend : w_evt;

    always_comb begin
        w_next_req             = '0;
        w_next_req[w_next.idx] = 1'b1;
    end

    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_rdata_unpack
        assign w_rdata_arr[gi] = slv_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_ack_hit   = slv_ack[r_cur.idx];
    assign w_sel_rdata = w_rdata_arr[r_cur.idx];

`ifdef FSMC_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] r_cnt;
`endif

    // ------------------------------------------------------------------------
    // Transaction FSM. The ack is honoured from the first request cycle so a
    // same-cycle ack completes in the minimum three cycles, and read data is
    // loaded on the ack edge so it is visible together with the request drop.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_q       <= '0;
            r_state_q    <= 1'b0;
            r_fsm        <= IDLE;
            r_cur        <= '0;
            r_pend       <= '0;
            r_pend_vld   <= 1'b0;
            slv_req      <= '0;
            host_rdata   <= '0;
            err_overrun  <= 1'b0;
            err_multi_cs <= 1'b0;
`ifdef FSMC_ARB_TIMEOUT_EN
            r_cnt        <= '0;
            err_timeout  <= 1'b0;
`endif
        end else begin
            r_cs_q <= cs;
            if (|(cs & ~r_cs_q)) begin
                r_state_q <= state;
            end

            if (w_evt_multi) begin
                err_multi_cs <= 1'b1;
            end else if (err_clr) begin
                err_multi_cs <= 1'b0;
            end

            if (w_overrun) begin
                err_overrun <= 1'b1;
            end else if (err_clr) begin
                err_overrun <= 1'b0;
            end

`ifdef FSMC_ARB_TIMEOUT_EN
            // A timeout in the FSM below overrides this clear.
            if (err_clr) begin
                err_timeout <= 1'b0;
            end
`endif

            if (w_buf_evt) begin
                r_pend     <= w_evt;
                r_pend_vld <= 1'b1;
            end else if (w_start_pend) begin
                r_pend_vld <= 1'b0;
            end

            case (r_fsm)
                IDLE, DONE: begin
                    if (w_start_pend | w_start_evt) begin
                        r_cur   <= w_next;
                        slv_req <= w_next_req;
                        r_fsm   <= ISSUE;
`ifdef FSMC_ARB_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end else begin
                        r_fsm <= IDLE;
                    end
                end
                ISSUE, WAIT: begin
                    if (w_ack_hit) begin
                        slv_req <= '0;
                        if (!r_cur.we) begin
                            host_rdata <= w_sel_rdata;
                        end
                        r_fsm <= DONE;
                    end
`ifdef FSMC_ARB_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        slv_req <= '0;
                        if (!r_cur.we) begin
                            host_rdata <= DEFAULT_RDATA;
                        end
                        err_timeout <= 1'b1;
                        r_fsm       <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        r_fsm <= WAIT;
                    end
`else
                    else begin
                        r_fsm <= WAIT;
                    end
`endif
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

`ifndef FSMC_ARB_TIMEOUT_EN
    assign err_timeout = 1'b0;
`endif

    // The in-flight record only changes when a new request is issued, so the
    // write strobe and data stay stable for the whole request.
    assign slv_we    = r_cur.we;
    assign slv_wdata = r_cur.data;
    assign busy      = (r_fsm != IDLE) | r_pend_vld;

endmodule
`default_nettype wire

// File: tb/tb_fsmc_slave_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsmc_slave_arbiter
//  Description : Self-checking bench for fsmc_slave_arbiter. Table vectors
//                drive host reads/writes; expected requests are queued at
//                drive time and popped when the request appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsmc_slave_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cs;
    logic        state;
    logic [15:0] host_wdata;
    logic [15:0] host_rdata;
    logic [3:0]  slv_req;
    logic        slv_we;
    logic [15:0] slv_wdata;
    logic [3:0]  slv_ack;
    logic [63:0] slv_rdata;
    logic        busy;
    logic        err_clr;
    logic        err_overrun;
    logic        err_multi_cs;
    logic        err_timeout;

    fsmc_slave_arbiter #(
        .CS_WIDTH       (2),
        .DATA_WIDTH     (16),
        .TIMEOUT_CYCLES (TO),
        .DEFAULT_RDATA  (16'hDEAD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cs           (cs),
        .state        (state),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .slv_req      (slv_req),
        .slv_we       (slv_we),
        .slv_wdata    (slv_wdata),
        .slv_ack      (slv_ack),
        .slv_rdata    (slv_rdata),
        .busy         (busy),
        .err_clr      (err_clr),
        .err_overrun  (err_overrun),
        .err_multi_cs (err_multi_cs),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        int          slv;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          dly;
    } vec_t;

    typedef struct {
        logic [3:0]  req;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] rdata_after;
    } exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    logic [15:0] model_rd;
    vec_t        vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit rd, input int s, input logic [15:0] wd, input logic [15:0] rdv);
        exp_t e;
        e.req   = 4'b0001 << s;
        e.we    = !rd;
        e.wdata = wd;
        if (rd) model_rd = rdv;
        e.rdata_after = model_rd;
        exp_q.push_back(e);
    endtask

    task automatic drive_read(input int s, input logic [15:0] rdv);
        push(1'b1, s, 16'h0000, rdv);
        cs    = 4'b0001 << s;
        state = 1'b1;
        tick;
        cs = 4'b0000;
    endtask

    task automatic drive_write(input int s, input logic [15:0] wd, input bit expect_issue);
        if (expect_issue) push(1'b0, s, wd, 16'h0000);
        cs    = 4'b0001 << s;
        state = 1'b0;
        tick;
        cs         = 4'b0000;
        host_wdata = wd;
        tick;
        host_wdata = ~wd;
    endtask

    // Waits for the next request, compares it with the scoreboard head,
    // holds it for dly cycles (acking a different slave meanwhile), then acks.
    task automatic serve(input int dly, input int exp_wait);
        exp_t e;
        int   waited = 0;
        int   s = 0;
        while (slv_req == 4'b0000 && waited < 20) begin
            tick;
            waited++;
        end
        chk("req_latency", waited, exp_wait);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: got request %b expected none", slv_req);
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) if (e.req[i]) s = i;
        chk("req", slv_req, e.req);
        chk("we", slv_we, e.we);
        if (e.we) chk("wdata", slv_wdata, e.wdata);
        for (int i = 0; i < 4; i++) slv_rdata[i*16 +: 16] = 16'(16'h1111 * (i + 1));
        slv_rdata[s*16 +: 16] = e.we ? ~e.rdata_after : e.rdata_after;
        for (int k = 0; k < dly; k++) begin
            slv_ack = 4'b0000;
            slv_ack[(s + 1) % 4] = 1'b1;
            tick;
            chk("req_hold", {slv_req, slv_we, (e.we ? slv_wdata : 16'h0000)},
                            {e.req, e.we, (e.we ? e.wdata : 16'h0000)});
        end
        slv_ack    = 4'b0000;
        slv_ack[s] = 1'b1;
        tick;
        slv_ack = 4'b0000;
        chk("req_drop", slv_req, 4'b0000);
        chk("host_rdata", host_rdata, e.rdata_after);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b1, 1, 16'h0000, 16'h1234, 2};
        vt[1] = '{1'b0, 2, 16'hA5A5, 16'h0000, 1};
        vt[2] = '{1'b1, 3, 16'h0000, 16'hBEEF, 0};
        vt[3] = '{1'b0, 0, 16'h0F0F, 16'h0000, 3};
        vt[4] = '{1'b1, 0, 16'h0000, 16'h8001, 1};
        vt[5] = '{1'b0, 3, 16'hFFFF, 16'h0000, 0};

        reset      = 1'b1;
        cs         = 4'b0000;
        state      = 1'b0;
        host_wdata = 16'h0000;
        slv_ack    = 4'b0000;
        slv_rdata  = '0;
        err_clr    = 1'b0;
        model_rd   = 16'h0000;
        repeat (3) tick;
        reset = 1'b0;
        tick;

        // Reset state
        chk("rst_req", slv_req, 4'b0000);
        chk("rst_we", slv_we, 1'b0);
        chk("rst_wdata", slv_wdata, 16'h0000);
        chk("rst_rdata", host_rdata, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", {err_overrun, err_multi_cs, err_timeout}, 3'b000);

        // Table vectors
        for (int v = 0; v < 6; v++) begin
            if (vt[v].rd) drive_read(vt[v].slv, vt[v].rdata);
            else          drive_write(vt[v].slv, vt[v].wdata, 1'b1);
            serve(vt[v].dly, 0);
            tick;
            chk("busy_idle", busy, 1'b0);
        end

        // Overrun: slave 0 stalls while two more writes arrive
        drive_write(0, 16'h0001, 1'b1);
        drive_write(1, 16'h0002, 1'b1);
        drive_write(2, 16'h0003, 1'b0);
        chk("overrun_set", err_overrun, 1'b1);
        chk("overrun_busy", busy, 1'b1);
        serve(0, 0);
        serve(1, 1);
        tick;
        chk("overrun_idle", {busy, slv_req}, 5'b0_0000);
        chk("overrun_sticky", err_overrun, 1'b1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("overrun_clr", err_overrun, 1'b0);
        chk("sb_drain", exp_q.size(), 0);

        // Multi-hot chip select
        cs    = 4'b0011;
        state = 1'b1;
        tick;
        chk("multi_set", err_multi_cs, 1'b1);
        chk("multi_noreq", {busy, slv_req}, 5'b0_0000);
        cs = 4'b0000;
        tick;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("multi_clr", err_multi_cs, 1'b0);
        cs      = 4'b0101;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        cs      = 4'b0000;
        chk("multi_set_wins", err_multi_cs, 1'b1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("multi_clr2", err_multi_cs, 1'b0);

        // Stalled read
`ifdef FSMC_ARB_TIMEOUT_EN
        begin
            exp_t e;
            int   n = 1;
            drive_read(2, 16'hDEAD);
            e = exp_q.pop_front();
            chk("to_req", slv_req, e.req);
            while (slv_req != 4'b0000 && n < 40) begin
                tick;
                if (slv_req != 4'b0000) n++;
            end
            chk("to_len", n, TO);
            chk("to_rdata", host_rdata, e.rdata_after);
            chk("to_flag", err_timeout, 1'b1);
            tick;
        end
`else
        drive_read(2, 16'h4242);
        repeat (12) tick;
        chk("no_to_req", slv_req, 4'b0100);
        chk("no_to_flag", err_timeout, 1'b0);
        serve(0, 0);
        tick;
`endif

        // Reset while waiting for an ack
        begin
            exp_t e;
            drive_read(1, 16'h9999);
            e = exp_q.pop_front();
            chk("rw_req", slv_req, e.req);
            tick;
            reset = 1'b1;
            tick;
            reset    = 1'b0;
            model_rd = 16'h0000;
            chk("rw_req_drop", slv_req, 4'b0000);
            chk("rw_busy", busy, 1'b0);
            slv_ack               = 4'b0010;
            slv_rdata[16 +: 16]   = 16'h9999;
            tick;
            slv_ack = 4'b0000;
            tick;
            chk("rw_late_ack", {busy, slv_req}, 5'b0_0000);
            chk("rw_rdata", host_rdata, model_rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
